// File: rtl/vec_pipe_stage.sv
// vec_pipe_stage: elastic pipeline register with a 2-entry skid buffer.
//
// The stage sits between two datapath stages. It carries the vector payload
// and the packed control bundle, and it lets the stages on either side stall
// independently. in_ready comes from a flop, so it never has a combinational
// path from out_ready.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   flush           discard every buffered entry (flush wins over all but rst)
//   in_valid/ready  upstream handshake (in_ready is registered)
//   in_data/ctrl    upstream payload and control bundle
//   out_valid/ready downstream handshake
//   out_data/ctrl   payload and control to the next stage (ctrl is 0 on bubbles)
//   occupancy       number of buffered entries, 0..2
//
// Optional build macro VEC_PIPE_STAGE_STATS_EN adds the stall_cnt and
// xfer_cnt outputs. These are saturating 16-bit counters, and only rst clears them.
//
// state | meaning
// ------+----------------------------------------------
// EMPTY | nothing buffered, out_valid=0
// ONE   | main register holds the head beat
// TWO   | main holds the head, skid holds the next beat, in_ready=0
module vec_pipe_stage #(
  parameter int LANES  = 6,
  parameter int LANE_W = 8,
  parameter int CTRL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]         in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [1:0]                occupancy
`ifdef VEC_PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               xfer_cnt
`endif
);

  localparam int DW = LANES * LANE_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_acc, out_acc;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = state;
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_acc) begin
          load_main_in = 1'b1;
          state_nxt    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_acc && out_acc) begin
          load_main_in = 1'b1;
        end else if (in_acc) begin
          load_skid = 1'b1;
          state_nxt = ST_TWO;
        end else if (out_acc) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_acc) begin
          load_main_skid = 1'b1;
          state_nxt      = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // A beat handshaken in the flush cycle is accepted but dropped here.
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
      if (flush) begin
        main_data <= '0;
        main_ctrl <= '0;
        skid_data <= '0;
        skid_ctrl <= '0;
      end else begin
        if (load_main_in) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
        end else if (state_nxt == ST_EMPTY) begin
          // Bubbles must not carry write enables downstream.
          main_ctrl <= '0;
        end
        if (load_skid) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
        end
      end
    end
  end

`ifdef VEC_PIPE_STAGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (out_acc && (xfer_cnt != 16'hFFFF))
        xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_pipe_stage.sv
// Scoreboard bench for vec_pipe_stage. The driver issues directed and random
// beats. A negedge monitor keeps a FIFO model of the accepted beats, checks
// every DUT output against that model and retires entries on output accept.
module tb_vec_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
`ifdef VEC_PIPE_STAGE_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] xfer_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [55:0] q[$];
  logic        zero_m = 1'b1;
  logic [15:0] stall_m = '0;
  logic [15:0] xfer_m  = '0;

  vec_pipe_stage #(.LANES(6), .LANE_W(8), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef VEC_PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor and reference model: a FIFO of at most two beats.
  always @(negedge clk) begin
    int sz;
    logic [55:0] head;
    if (rst) begin
      q.delete();
      zero_m  = 1'b1;
      stall_m = '0;
      xfer_m  = '0;
    end else begin
      sz = q.size();
      chk("occupancy", {62'd0, occupancy}, 64'(sz));
      chk("in_ready", {63'd0, in_ready}, {63'd0, (sz < 2)});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (sz > 0)});
      if (sz > 0) begin
        head = q[0];
        chk("out_data", {16'd0, out_data}, {16'd0, head[55:8]});
        chk("out_ctrl", {56'd0, out_ctrl}, {56'd0, head[7:0]});
      end else begin
        chk("bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
        if (zero_m) chk("bubble_data", {16'd0, out_data}, 64'd0);
      end
`ifdef VEC_PIPE_STAGE_STATS_EN
      chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, stall_m});
      chk("xfer_cnt", {48'd0, xfer_cnt}, {48'd0, xfer_m});
`endif
      if (sz > 0 && !out_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
      if (sz > 0 && out_ready && xfer_m != 16'hFFFF) xfer_m = xfer_m + 16'd1;
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (in_valid && sz < 2) begin
        q.push_back({in_data, in_ctrl});
        zero_m = 1'b0;
      end
      if (flush) begin
        q.delete();
        zero_m = 1'b1;
      end
    end
  end

  task automatic cyc(input logic v, input logic [47:0] d, input logic [7:0] c,
                     input logic ordy, input logic fl, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, then idle
    cyc(0, '0, '0, 0, 0, 1);
    cyc(0, '0, '0, 0, 0, 1);
    cyc(0, '0, '0, 0, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // streaming
    for (int k = 0; k < 4; k++)
      cyc(1, 48'h010203040506 + 48'(k), 8'h80 + 8'(k), 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // backpressure then drain
    cyc(1, 48'hAAAA, 8'h11, 0, 0, 0);
    cyc(1, 48'hBBBB, 8'h22, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, '0, '0, 1, 0, 0);

    // flush at occupancy 2 with a beat C presented
    cyc(1, 48'hAAAA, 8'h11, 0, 0, 0);
    cyc(1, 48'hBBBB, 8'h22, 0, 0, 0);
    cyc(1, 48'hCCCC, 8'h33, 0, 1, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // flush at occupancy 1 with a handshaken beat that must be dropped
    cyc(1, 48'h5555, 8'h44, 0, 0, 0);
    cyc(1, 48'h6666, 8'h55, 0, 1, 0);
    cyc(0, '0, '0, 1, 1, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // reset mid-stream, then push D
    cyc(1, 48'h777777, 8'h66, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 1);
    cyc(1, 48'h123456789ABC, 8'h77, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          {16'($urandom), $urandom},
          8'($urandom),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 23) == 0,
          $urandom_range(0, 255) == 0);
    end

    // drain: the model FIFO must empty
    for (int k = 0; k < 4; k++) cyc(0, '0, '0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
    #3;

`ifdef VEC_PIPE_STAGE_STATS_EN
    cyc(0, '0, '0, 0, 0, 1);
    cyc(1, 48'hE0E0, 8'h01, 0, 0, 0);
    cyc(1, 48'hF0F0, 8'h02, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("stall_cnt_3", {48'd0, stall_cnt}, 64'd3);
    chk("xfer_cnt_2", {48'd0, xfer_cnt}, 64'd2);
    #3;
    cyc(1, 48'h9999, 8'h09, 0, 0, 0);
    for (int k = 0; k < 70000; k++) cyc(0, '0, '0, 0, 1'b0, 0);
    @(negedge clk);
    #1;
    chk("stall_cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);
    #3;
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_pipe_stage.md
Name: vec_pipe_stage

Overview:
- Parametrised elastic pipeline register for the vector processor datapath.
- Generalises the fixed ALU→MEM and MEM→WB stage registers: configurable lane count, lane width and control-bundle width; valid/ready handshake; 2-entry skid buffer; flush.
- Lets stages stall independently without combinational ready paths between them.
- Inserted between any two pipeline stages; carries the vector payload plus the packed control bundle (regWrite, memWrite, memToReg, PCSrc, WA3, ...).

Parameters:
- LANES, 6, number of vector lanes.
- LANE_W, 8, bits per lane; payload width is LANES*LANE_W (default 48).
- CTRL_W, 8, width of the packed control bundle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill all buffered entries (branch taken / PCSrc resolve).
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat; driven from a register.
- in_data  input  LANES*LANE_W  upstream vector payload.
- in_ctrl  input  CTRL_W  upstream control bundle.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  LANES*LANE_W  payload to next stage.
- out_ctrl  output  CTRL_W  control bundle to next stage.
- occupancy  output  2  buffered entries, 0..2.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_ctrl=0, occupancy=0, skid entry empty and zeroed.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output accept = out_valid & out_ready.
  - in_ready never depends combinationally on out_ready.
- Latency: 1 cycle. A beat accepted in cycle N appears on out_* in cycle N+1 when the stage was empty.
- Internal storage: main register (drives out_*) and skid register.
- State EMPTY (occ 0):
  - out_valid=0.
  - Input accept → main<=in → ONE.
- State ONE (occ 1):
  - In+out accept → main<=in, stay ONE.
  - In only → skid<=in, in_ready<=0 → TWO.
  - Out only → EMPTY.
  - Neither → hold.
- State TWO (occ 2):
  - in_ready=0.
  - Out accept → main<=skid, in_ready<=1 → ONE.
  - Otherwise hold.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush.
- Data stability: out_data and out_ctrl stay stable while out_valid=1 and out_ready=0.
- Flush (priority over everything except rst):
  - Next cycle: occ=0, out_valid=0, in_ready=1, out_ctrl=0, skid cleared.
  - A beat presented with in_valid & in_ready in the flush cycle counts as handshaken but is discarded.
- Flush with occ=0: no visible effect other than forcing out_ctrl=0.
- rst mid-operation: same as the reset values above; in-flight beats are lost.
- Control masking: out_ctrl is 0 whenever out_valid=0, so downstream write enables stay inactive on bubbles.
- out_data contents are don't-care when invalid, except after reset or flush, where they are 0.

Optional Feature:
- Macro: VEC_PIPE_STAGE_STATS_EN.
- When defined:
  - Adds output stall_cnt [15:0]: increments each cycle out_valid=1 & out_ready=0.
  - Adds output xfer_cnt [15:0]: increments on each output accept.
  - Both saturate at 16'hFFFF.
  - Both clear on rst only; flush does not clear them.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → out_valid=0, in_ready=1, occupancy=0, out_ctrl=0.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with data 48'h010203040506+k, ctrl 8'h80+k (k=0..3) → same values on out_* cycles 1..4 later, in_ready stays 1, occupancy stays 1.
- Backpressure: out_ready=0, push A=48'hAAAA, then B=48'hBBBB → occupancy=2, in_ready=0, out_data=AAAA held. Raise out_ready → A then B in consecutive cycles; in_ready returns to 1 one cycle after A drains.
- Flush at occ=2 with a simultaneous in_valid beat C → next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1; A, B, C never appear.
- Reset mid-stream at occ=1 → next cycle all outputs at reset values. A subsequent push D=48'h123456789ABC appears unchanged one cycle later.
- With VEC_PIPE_STAGE_STATS_EN: 3 stalled cycles then 2 transfers → stall_cnt=3, xfer_cnt=2. Force 70000 stall cycles → stall_cnt=16'hFFFF.
